// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and helpers for the Simon player input path
package simon_pkg;

  localparam int NUM_BTNS = 4;

  typedef logic [1:0] colour_t;

  typedef enum logic [1:0] {
    LOCKED,
    WAIT_RELEASE,
    ARMED,
    FIRE
  } player_state_t;

  function automatic colour_t onehot_to_idx(input logic [NUM_BTNS-1:0] v);
    colour_t idx;
    idx = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (v[i]) idx = colour_t'(i);
    end
    return idx;
  endfunction

  function automatic logic is_single(input logic [NUM_BTNS-1:0] v);
    return (v != '0) && ((v & (v - NUM_BTNS'(1))) == '0);
  endfunction

endpackage

// File: rtl/simon_player_input_if.sv
// rtl/simon_player_input_if.sv - button inputs, lock inputs and press stream outputs
interface simon_player_input_if;
  import simon_pkg::*;

  logic [NUM_BTNS-1:0] btn;
  logic                simonTurn;
  logic                gameOver;
  colour_t             playerNum;
  logic                playerPressed;
  logic                invalidPress;
  logic [NUM_BTNS-1:0] echoLed;

  modport master (
    input  btn, simonTurn, gameOver,
    output playerNum, playerPressed, invalidPress, echoLed
  );

  modport slave (
    output btn, simonTurn, gameOver,
    input  playerNum, playerPressed, invalidPress, echoLed
  );

endinterface

// File: rtl/simon_player_input_button_debouncer.sv
// rtl/simon_player_input_button_debouncer.sv - 2-flop synchronizer plus stable-count debouncer for one button
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      if (sync_q == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync_q;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/simon_player_input.sv
// rtl/simon_player_input.sv - debounced, locked-out player press encoder for the Simon engine
// Optional LED echo of accepted colour compiled in with SIMON_PLAYER_ECHO_EN.
module simon_player_input
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int ECHO_CYCLES     = 15
) (
  input logic                 clk,
  input logic                 reset,
  simon_player_input_if.master io
);

  logic [NUM_BTNS-1:0] deb;
  logic                lock;
  logic                single;
  logic                multi;
  player_state_t       state;
  player_state_t       state_d;
  logic                fire_d;
  logic                invalid_d;
  logic                load_num;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (io.btn[g]),
      .level (deb[g])
    );
  end

  assign lock   = io.simonTurn | io.gameOver;
  assign single = is_single(deb);
  assign multi  = (deb != '0) && !single;

  // After reset the debounced levels read 0 until a held button has had time to
  // re-debounce; release is not trusted before then.
  localparam int SETTLE = DEBOUNCE_CYCLES + 2;
  localparam int SW     = $clog2(SETTLE + 1);
  logic [SW-1:0] settle_cnt;
  logic          settled;

  assign settled = (settle_cnt == SW'(SETTLE));

  always_ff @(posedge clk) begin
    if (reset) settle_cnt <= '0;
    else if (!settled) settle_cnt <= settle_cnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= LOCKED;
    else state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (lock) begin
      state_d = LOCKED;
    end else begin
      case (state)
        LOCKED:       state_d = WAIT_RELEASE;
        WAIT_RELEASE: if (settled && deb == '0) state_d = ARMED;
        ARMED: begin
          if (single) state_d = FIRE;
          else if (multi) state_d = WAIT_RELEASE;
        end
        FIRE:         state_d = WAIT_RELEASE;
        default:      state_d = LOCKED;
      endcase
    end
  end

  always_comb begin
    fire_d    = 1'b0;
    invalid_d = 1'b0;
    load_num  = 1'b0;
    if (!lock) begin
      fire_d    = (state == FIRE);
      invalid_d = (state == ARMED) && multi;
      load_num  = (state == ARMED) && single;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io.playerNum     <= '0;
      io.playerPressed <= 1'b0;
      io.invalidPress  <= 1'b0;
    end else begin
      io.playerPressed <= fire_d;
      io.invalidPress  <= invalid_d;
      if (load_num) io.playerNum <= onehot_to_idx(deb);
    end
  end

`ifdef SIMON_PLAYER_ECHO_EN
  localparam int EW = $clog2(ECHO_CYCLES + 1);
  logic [EW-1:0]       echo_cnt;
  logic [NUM_BTNS-1:0] echo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      echo_cnt <= '0;
      echo_q   <= '0;
    end else if (fire_d) begin
      echo_q   <= NUM_BTNS'(1) << io.playerNum;
      echo_cnt <= EW'(ECHO_CYCLES);
    end else if (lock) begin
      echo_q   <= '0;
      echo_cnt <= '0;
    end else if (echo_cnt != '0) begin
      echo_cnt <= echo_cnt - EW'(1);
      if (echo_cnt == EW'(1)) echo_q <= '0;
    end
  end

  assign io.echoLed = echo_q;
`else
  assign io.echoLed = '0;
`endif

endmodule

// File: tb/tb_simon_player_input.sv
// tb/tb_simon_player_input.sv - directed bench for simon_player_input with a cycle model
module tb_simon_player_input;
  import simon_pkg::*;

  localparam int DEB  = 3;
  localparam int ECHO = 15;
`ifdef SIMON_PLAYER_ECHO_EN
  localparam int ECHO_ON = 1;
`else
  localparam int ECHO_ON = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simon_player_input_if bus();

  simon_player_input #(.DEBOUNCE_CYCLES(DEB), .ECHO_CYCLES(ECHO)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%0d required=%0d edge=%0d", name, act, exp, cyc);
    end
  endtask

  // Model: raw history per edge, debounced levels derived from runs of samples
  logic [3:0] raw_h [0:2047];
  int         rst_edge = 0;
  int         last_flip [4];
  logic [3:0] m_deb;
  bit         m_locked, m_wait, m_armed, m_firing;
  logic       m_pulse, m_inv;
  logic [1:0] m_num;
  logic [3:0] m_led;
  int         m_left;
  bit         model_ok = 0;

  function automatic logic samp(input int x, input int b);
    if (x - 2 > rst_edge) return raw_h[x-2][b];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit lk;
    int n;
    cyc++;
    raw_h[cyc] = bus.btn;
    lk = bus.simonTurn | bus.gameOver;
    if (reset) begin
      rst_edge = cyc;
      for (int b = 0; b < 4; b++) last_flip[b] = cyc;
      m_deb = 0; m_locked = 1; m_wait = 0; m_armed = 0; m_firing = 0;
      m_pulse = 0; m_inv = 0; m_num = 0; m_led = 0; m_left = 0;
      model_ok = 1;
    end else begin
      n = $countones(m_deb);
      m_pulse = m_firing && !lk;
      m_inv   = m_armed && !lk && n >= 2;
      if (m_armed && !lk && n == 1)
        for (int i = 0; i < 4; i++) if (m_deb[i]) m_num = 2'(i);
      if (lk) begin
        m_locked = 1; m_wait = 0; m_armed = 0; m_firing = 0;
      end else if (m_locked) begin
        m_locked = 0; m_wait = 1;
      end else if (m_wait) begin
        if (m_deb == 0 && cyc - rst_edge > DEB + 2) begin m_wait = 0; m_armed = 1; end
      end else if (m_armed) begin
        if (n == 1) begin m_armed = 0; m_firing = 1; end
        else if (n >= 2) begin m_armed = 0; m_wait = 1; end
      end else if (m_firing) begin
        m_firing = 0; m_wait = 1;
      end
      if (ECHO_ON != 0) begin
        if (m_pulse) begin m_led = 4'b0001 << m_num; m_left = ECHO; end
        else if (lk) begin m_led = 0; m_left = 0; end
        else if (m_left > 0) begin m_left--; if (m_left == 0) m_led = 0; end
      end
      for (int b = 0; b < 4; b++) begin
        if (cyc - 2 > last_flip[b] && samp(cyc, b) != m_deb[b] &&
            samp(cyc - 1, b) != m_deb[b] && samp(cyc - 2, b) != m_deb[b]) begin
          m_deb[b] = ~m_deb[b];
          last_flip[b] = cyc;
        end
      end
    end
  end

  int   pulse_cnt = 0, inv_cnt = 0, echo2_cnt = 0, last_pulse = -1;
  logic [1:0] last_num = 0;
  logic prev_p = 0;

  always @(negedge clk) begin
    if (model_ok) begin
      chk("pressed", 32'(bus.playerPressed), 32'(m_pulse));
      chk("invalid", 32'(bus.invalidPress), 32'(m_inv));
      chk("num", 32'(bus.playerNum), 32'(m_num));
      chk("echo", 32'(bus.echoLed), 32'(m_led));
      chk("spacing", 32'(bus.playerPressed && prev_p), 32'd0);
      if (bus.playerPressed) begin pulse_cnt++; last_pulse = cyc; last_num = bus.playerNum; end
      if (bus.invalidPress) inv_cnt++;
      if (bus.echoLed == 4'b0010) echo2_cnt++;
      prev_p = bus.playerPressed;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, p0, i0, e0;
    reset = 1; bus.btn = 0; bus.simonTurn = 0; bus.gameOver = 0;
    step(3);
    reset = 0;
    step(1);
    chk("rst_pressed", 32'(bus.playerPressed), 0);
    chk("rst_invalid", 32'(bus.invalidPress), 0);
    chk("rst_num", 32'(bus.playerNum), 0);
    chk("rst_echo", 32'(bus.echoLed), 0);
    step(10);

    // 1: clean press of colour 2 held for 20 cycles
    p0 = pulse_cnt; bus.btn = 4'b0100; k = cyc + 1;
    step(20);
    chk("t1_pulses", pulse_cnt - p0, 1);
    chk("t1_latency", last_pulse, k + 6);
    chk("t1_num", 32'(last_num), 2);
    bus.btn = 0; step(10);

    // 2: two-sample glitch on button 1
    p0 = pulse_cnt; i0 = inv_cnt;
    bus.btn = 4'b0010; step(2); bus.btn = 0; step(10);
    chk("t2_pulses", pulse_cnt - p0, 0);
    chk("t2_invalid", inv_cnt - i0, 0);

    // 3: two buttons together, then a clean colour 3
    p0 = pulse_cnt; i0 = inv_cnt;
    bus.btn = 4'b0011; step(12);
    chk("t3_invalid", inv_cnt - i0, 1);
    chk("t3_no_pulse", pulse_cnt - p0, 0);
    bus.btn = 0; step(8);
    bus.btn = 4'b1000; step(12);
    chk("t3_pulse", pulse_cnt - p0, 1);
    chk("t3_num", 32'(last_num), 3);
    bus.btn = 0; step(8);

    // 4: press during Simon's turn, lock drops while held
    p0 = pulse_cnt;
    bus.simonTurn = 1; bus.btn = 4'b0001; step(12);
    chk("t4_locked", pulse_cnt - p0, 0);
    bus.simonTurn = 0; step(12);
    chk("t4_held", pulse_cnt - p0, 0);
    bus.btn = 0; step(8);
    bus.btn = 4'b0001; step(12);
    chk("t4_repress", pulse_cnt - p0, 1);
    chk("t4_num", 32'(last_num), 0);
    bus.btn = 0; step(8);

    // 5: echo length, then lock mid-echo
    p0 = pulse_cnt; e0 = echo2_cnt;
    bus.btn = 4'b0010; step(8); bus.btn = 0; step(25);
    chk("t5_pulse", pulse_cnt - p0, 1);
    chk("t5_echo_len", echo2_cnt - e0, ECHO_ON * 15);
    p0 = pulse_cnt;
    bus.btn = 4'b0010;
    for (int i = 0; i < 20 && pulse_cnt == p0; i++) step(1);
    chk("t5_wait_pulse", pulse_cnt - p0, 1);
    step(4);
    chk("t5_echo_before", 32'(bus.echoLed), ECHO_ON * 2);
    bus.simonTurn = 1; step(1);
    chk("t5_echo_cleared", 32'(bus.echoLed), 0);
    bus.simonTurn = 0; bus.btn = 0; step(10);

    // 6: reset mid-hold
    p0 = pulse_cnt;
    bus.btn = 4'b0100; step(12);
    chk("t6_first", pulse_cnt - p0, 1);
    reset = 1; step(1); reset = 0;
    chk("t6_rst_pressed", 32'(bus.playerPressed), 0);
    chk("t6_rst_num", 32'(bus.playerNum), 0);
    chk("t6_rst_echo", 32'(bus.echoLed), 0);
    p0 = pulse_cnt;
    step(15);
    chk("t6_held", pulse_cnt - p0, 0);
    bus.btn = 0; step(8);
    bus.btn = 4'b0100; step(12);
    chk("t6_repress", pulse_cnt - p0, 1);
    chk("t6_num", 32'(last_num), 2);
    bus.btn = 0; step(8);

    // 7: game over blocks presses
    p0 = pulse_cnt;
    bus.gameOver = 1; bus.btn = 4'b0001; step(12);
    chk("t7_gameover", pulse_cnt - p0, 0);
    bus.btn = 0; step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simon_player_input.md
Name: simon_player_input

Overview:
- Player-side front end of the Simon turn interface. Produces the player press stream (`playerNum`, `playerPressed`) that the Simon game engine consumes.
- Synchronizes and debounces four raw push buttons, then encodes one press to a 2-bit colour number.
- Emits exactly one single-cycle pulse per physical press.
- Locks out input during Simon's turn and after game over. Optionally echoes the accepted colour on LEDs.

Parameters:
- DEBOUNCE_CYCLES, 3: consecutive stable synchronized samples needed to change a debounced button level (about 50 ms at 60 Hz).
- ECHO_CYCLES, 15: cycles `echoLed` stays lit after an accepted press.

Ports:
- clk  in  1  system clock (60 Hz); one clock domain only.
- reset  in  1  synchronous, active-high reset.
- btn  in  4  raw buttons, active-high, asynchronous to `clk`; bit i = colour i.
- simonTurn  in  1  high while Simon plays its sequence.
- gameOver  in  1  high once the game has ended.
- playerNum  out  2  encoded colour of the last accepted press; holds its value between presses.
- playerPressed  out  1  single-cycle strobe; `playerNum` is valid in the same cycle.
- invalidPress  out  1  single-cycle strobe when more than one button is debounced-high at acceptance.
- echoLed  out  4  one-hot echo of the accepted colour.

Behaviour:
- Reset values:
  - all outputs 0;
  - sync flops, debounced levels and counters 0;
  - FSM state LOCKED.
- Input conditioning:
  - Per button: 2-flop synchronizer, then debouncer.
  - Debounce counter increments while the synchronized bit differs from the debounced bit; it clears when they match.
  - At count == DEBOUNCE_CYCLES-1 the debounced bit takes the new value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES samples are rejected.
- FSM states:
  - LOCKED: stays while `simonTurn` | `gameOver`; otherwise goes to WAIT_RELEASE.
  - WAIT_RELEASE: goes to ARMED when debounced == 4'b0000.
  - ARMED:
    - debounced has exactly one bit set: go to FIRE; register `playerNum` = index of that bit.
    - two or more bits set: `invalidPress` = 1 next cycle; go to WAIT_RELEASE.
  - FIRE: `playerPressed` = 1 for exactly this cycle; go to WAIT_RELEASE.
- Lock priority:
  - `simonTurn` | `gameOver` high in any state forces LOCKED at the next edge.
  - A press decoded in the same cycle as lock rises is discarded; no strobe is issued.
- Latency:
  - A clean press first sampled high at edge k asserts `playerPressed` in the cycle after edge k+DEBOUNCE_CYCLES+3. With the default of 3, that is after edge k+6.
- Spacing: release is mandatory between pulses, so `playerPressed` never asserts in two adjacent cycles. The consumer always gets at least one idle cycle.
- Holding a button never produces a second pulse.
- Button held when the lock falls: no pulse until it is released and pressed again (WAIT_RELEASE).
- Reset mid-hold: the FSM restarts in LOCKED and debounced levels start at 0.
  - The held button re-debounces high while the FSM is in LOCKED or WAIT_RELEASE, so no pulse is produced until release.
- Echo (see Optional Feature):
  - On FIRE, `echoLed` = 1 << `playerNum` and the echo counter loads ECHO_CYCLES.
  - The counter decrements each cycle; `echoLed` clears when it reaches 0.
  - A new FIRE reloads the counter.
  - Entering LOCKED clears `echoLed` at the next edge.
- Width: echo counter width = $clog2(ECHO_CYCLES+1); debounce counter width = $clog2(DEBOUNCE_CYCLES+1).

Optional Feature:
- Macro: SIMON_PLAYER_ECHO_EN.
- Defined: the echo counter and the `echoLed` behaviour above are compiled in.
- Undefined: the echo logic is omitted and `echoLed` is tied to 4'b0000. All other behaviour is identical.

Decomposition:
- Shared package `simon_pkg`:
  - NUM_BTNS = 4;
  - colour_t (2-bit) typedef;
  - player FSM state enum (LOCKED, WAIT_RELEASE, ARMED, FIRE);
  - onehot-to-index function;
  - single-bit-set check function.
- Sub-module `button_debouncer`: 1-bit synchronizer plus debounce counter, parameterized by DEBOUNCE_CYCLES, instantiated NUM_BTNS times.

Test Plan:
1. Reset, `simonTurn`=0, `gameOver`=0; `btn`=4'b0100 stable for 20 cycles. Response: one `playerPressed` in the cycle after edge k+6 with `playerNum`=2; no further pulse while held.
2. `btn[1]` high for 2 cycles only. Response: no `playerPressed`, no `invalidPress`.
3. `btn`=4'b0011 pressed together. Response: `invalidPress` for 1 cycle, no `playerPressed`. Then release and press 4'b1000. Response: `playerPressed` with `playerNum`=3.
4. `simonTurn`=1 while `btn`=4'b0001. Response: no pulse. Drop `simonTurn` with the button still held. Response: no pulse. Release and repress. Response: pulse with `playerNum`=0.
5. SIMON_PLAYER_ECHO_EN defined; accepted press of colour 1. Response: `echoLed`=4'b0010 for exactly 15 cycles. Repeat, raising `simonTurn` at echo cycle 5. Response: `echoLed`=0 at the next edge. With the macro undefined, `echoLed` stays 0 throughout.
6. Assert `reset` for 1 cycle mid-hold of 4'b0100. Response: all outputs 0 after reset; no pulse until release and a new press.
